// File: rtl/font_glyph_serializer.sv
// Font ROM read port plus pixel serializer: fetches one glyph row per request
// and streams its pixels MSB-first with column index and end-of-row flag.
module font_glyph_serializer #(
    parameter int CHAR_W  = 7,
    parameter int ROW_W   = 4,
    parameter int ADDR_W  = 11,
    parameter int GLYPH_W = 8
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CHAR_W-1:0]     req_char,
    input  logic [ROW_W-1:0]      req_row,
    input  logic                  req_inv,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [GLYPH_W-1:0]    rom_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_data,
    output logic [2:0]            pix_col,
    output logic                  pix_last
);

    localparam logic [2:0] COL_MAX = 3'(GLYPH_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 inv_q, inv_d;
    logic [GLYPH_W-1:0]   hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [GLYPH_W-1:0]   shift_q, shift_d;
    logic [2:0]           col_q, col_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic                 req_fire_s;
    logic                 pix_fire_s;
    logic                 capture_s;
    logic                 load_s;

    // A new fetch may start only once the previous byte has left the holding buffer.
    assign req_ready  = (state_q == ST_IDLE) && !hold_full_q && !rsta;
    assign req_fire_s = req_valid && req_ready;
    assign pix_fire_s = valid_q && pix_ready;

    assign rom_addr  = addr_q;
    assign pix_valid = valid_q;
    assign pix_data  = shift_q[GLYPH_W-1];
    assign pix_col   = col_q;
    assign pix_last  = last_q;

    // Fetch FSM: address issue, one ROM latency cycle, then capture into hold.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        inv_d     = inv_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_fire_s) begin
                    addr_d  = {req_char, req_row};
                    inv_d   = req_inv;
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                capture_s = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shifter reloads on the very edge its last pixel leaves, keeping rows gapless.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        col_d       = col_q;
        valid_d     = valid_q;
        load_s      = hold_full_q && (!valid_q || (pix_fire_s && last_q));
        if (load_s) begin
            shift_d     = hold_q;
            col_d       = 3'd0;
            valid_d     = 1'b1;
            hold_full_d = 1'b0;
        end else if (pix_fire_s) begin
            shift_d = {shift_q[GLYPH_W-2:0], 1'b0};
            if (last_q) begin
                col_d   = 3'd0;
                valid_d = 1'b0;
            end else begin
                col_d = col_q + 3'd1;
            end
        end else begin
            shift_d = shift_q;
        end
        if (capture_s) begin
            hold_d      = rom_data ^ {GLYPH_W{inv_q}};
            hold_full_d = 1'b1;
        end else begin
            hold_d = hold_d;
        end
        last_d = valid_d && (col_d == COL_MAX);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            inv_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            col_q       <= 3'd0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            inv_q       <= inv_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            col_q       <= col_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_font_glyph_serializer.sv
// Directed bench for font_glyph_serializer with a registered-read font ROM model.
module tb_font_glyph_serializer;

    logic        clka = 1'b0;
    logic        rsta;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_char;
    logic [3:0]  req_row;
    logic        req_inv;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_data;
    logic [2:0]  pix_col;
    logic        pix_last;

    logic [7:0]  rom [0:2047];
    logic [4:0]  pq [$];
    int          sq [$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    font_glyph_serializer dut (
        .clka(clka), .rsta(rsta),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_char(req_char), .req_row(req_row), .req_inv(req_inv),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_col(pix_col), .pix_last(pix_last)
    );

    always #5 clka = ~clka;

    always @(posedge clka) rom_data <= rom[rom_addr];

    // Record every accepted pixel with its cycle stamp.
    always @(posedge clka) begin
        cyc <= cyc + 1;
        if (!rsta && pix_valid && pix_ready) begin
            pq.push_back({pix_col, pix_last, pix_data});
            sq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [6:0] ch, input logic [3:0] row, input logic inv);
        int n = 0;
        req_valid = 1'b1;
        req_char  = ch;
        req_row   = row;
        req_inv   = inv;
        while (!req_ready && n < 100) begin
            @(negedge clka);
            n++;
        end
        chk("req accept timeout", 32'(req_ready), 32'd1);
        @(posedge clka);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_col(input logic [2:0] c);
        int n = 0;
        do begin
            @(negedge clka);
            n++;
        end while (!(pix_valid && pix_col == c) && n < 100);
        chk("wait col timeout", 32'(pix_valid && pix_col == c), 32'd1);
    endtask

    task automatic expect_glyph(input string tag, input logic [7:0] exp);
        int n = 0;
        logic [4:0]  r;
        logic [7:0]  data = 8'h00;
        logic [7:0]  lasts = 8'h00;
        logic [23:0] cols = 24'h000000;
        while (pq.size() < 8 && n < 100) begin
            @(posedge clka);
            #1;
            n++;
        end
        chk({tag, " pixel count"}, 32'(pq.size() >= 8), 32'd1);
        if (pq.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                r     = pq.pop_front();
                data  = {data[6:0], r[0]};
                lasts = {lasts[6:0], r[1]};
                cols  = {cols[20:0], r[4:2]};
            end
            chk({tag, " data"}, 32'(data), 32'(exp));
            chk({tag, " cols"}, 32'(cols), 32'h053977);
            chk({tag, " last"}, 32'(lasts), 32'h01);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 2048; a++) rom[a] = 8'h00;
        rom[11'h412] = 8'h10;
        rom[11'h413] = 8'h38;
        rom[11'h414] = 8'h6C;
        rom[11'h417] = 8'hFE;

        // 1: reset holds off requests
        rsta = 1'b1; req_valid = 1'b1; req_char = 7'h41; req_row = 4'd7;
        req_inv = 1'b0; pix_ready = 1'b1;
        repeat (3) begin
            @(negedge clka);
            chk("rst req_ready", 32'(req_ready), 32'd0);
            chk("rst pix_valid", 32'(pix_valid), 32'd0);
            chk("rst rom_addr", 32'(rom_addr), 32'h000);
        end
        rsta = 1'b0; req_valid = 1'b0;
        #1;
        chk("post-rst req_ready", 32'(req_ready), 32'd1);
        @(negedge clka);
        chk("post-rst rom_addr", 32'(rom_addr), 32'h000);

        // 2: single fetch, latency and plain pixels
        pq.delete();
        send_req(7'h41, 4'd7, 1'b0);
        chk("t2 rom_addr", 32'(rom_addr), 32'h417);
        chk("t2 valid E0", 32'(pix_valid), 32'd0);
        @(posedge clka); #1;
        chk("t2 valid E1", 32'(pix_valid), 32'd0);
        @(posedge clka); #1;
        chk("t2 valid E2", 32'(pix_valid), 32'd0);
        @(posedge clka); #1;
        chk("t2 valid E3", 32'(pix_valid), 32'd1);
        chk("t2 col E3", 32'(pix_col), 32'd0);
        expect_glyph("t2", 8'hFE);
        chk("t2 valid after", 32'(pix_valid), 32'd0);

        // 3: inverted fetch
        @(negedge clka);
        pq.delete();
        send_req(7'h41, 4'd7, 1'b1);
        expect_glyph("t3", 8'h01);

        // 4: three back-to-back rows must stream without gaps
        @(negedge clka);
        pq.delete(); sq.delete();
        fork
            begin
                send_req(7'h41, 4'd2, 1'b0);
                send_req(7'h41, 4'd3, 1'b0);
                send_req(7'h41, 4'd4, 1'b0);
            end
        join_none
        expect_glyph("t4 row2", 8'h10);
        expect_glyph("t4 row3", 8'h38);
        expect_glyph("t4 row4", 8'h6C);
        chk("t4 stamps", 32'(sq.size()), 32'd24);
        if (sq.size() >= 24) chk("t4 gapless span", 32'(sq[23] - sq[0]), 32'd23);

        // 5: back-pressure at col 3 with a second row waiting in hold
        @(negedge clka);
        pq.delete();
        fork
            begin
                send_req(7'h41, 4'd2, 1'b0);
                send_req(7'h41, 4'd7, 1'b0);
            end
        join_none
        wait_col(3'd3);
        pix_ready = 1'b0;
        repeat (5) begin
            @(negedge clka);
            chk("t5 stall valid", 32'(pix_valid), 32'd1);
            chk("t5 stall col", 32'(pix_col), 32'd3);
            chk("t5 stall data", 32'(pix_data), 32'd1);
            chk("t5 stall last", 32'(pix_last), 32'd0);
            chk("t5 stall req_ready", 32'(req_ready), 32'd0);
        end
        pix_ready = 1'b1;
        expect_glyph("t5 first", 8'h10);
        chk("t5 req_ready after load", 32'(req_ready), 32'd1);
        expect_glyph("t5 second", 8'hFE);
        chk("t5 leftover pixels", 32'(pq.size()), 32'd0);
        chk("t5 valid after", 32'(pix_valid), 32'd0);

        // 6: reset at col 4 while the next fetch sits in WAIT
        @(negedge clka);
        pq.delete();
        send_req(7'h41, 4'd3, 1'b0);
        wait_col(3'd2);
        send_req(7'h41, 4'd4, 1'b0);
        @(negedge clka);
        @(negedge clka);
        chk("t6 col before rst", 32'(pix_col), 32'd4);
        rsta = 1'b1;
        @(negedge clka);
        chk("t6 rst valid", 32'(pix_valid), 32'd0);
        chk("t6 rst col", 32'(pix_col), 32'd0);
        chk("t6 rst last", 32'(pix_last), 32'd0);
        chk("t6 rst req_ready", 32'(req_ready), 32'd0);
        chk("t6 rst rom_addr", 32'(rom_addr), 32'h000);
        rsta = 1'b0;
        #1;
        chk("t6 idle req_ready", 32'(req_ready), 32'd1);
        @(negedge clka);
        chk("t6 no ghost pixel", 32'(pix_valid), 32'd0);
        pq.delete();
        send_req(7'h41, 4'd7, 1'b0);
        expect_glyph("t6 clean", 8'hFE);
        chk("t6 valid after", 32'(pix_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/font_glyph_serializer.md
Name: font_glyph_serializer

Overview:
- Reading end of the 2048x8 font ROM (128 glyphs x 16 rows, 8 px/row, address = {char[6:0], row[3:0]}).
- Accepts glyph-row requests (char code, row, invert) on a valid/ready handshake and drives the ROM address.
- Captures the ROM's registered read data and serializes it MSB-first as a 1-bit pixel stream with valid/ready.
- Sits between the text-mode character/attribute fetch and the video pixel mux.

Parameters:
CHAR_W, 7, character code width
ROW_W, 4, glyph row index width
ADDR_W, 11, ROM address width; must equal CHAR_W+ROW_W
GLYPH_W, 8, pixels per glyph row = ROM data width

Ports:
clka  in  1  clock, rising edge; shared with font ROM
rsta  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accept
req_char  in  CHAR_W  character code
req_row  in  ROW_W  glyph row 0..15
req_inv  in  1  invert pixels (cursor/reverse video)
rom_addr  out  ADDR_W  to ROM addra, registered
rom_data  in  GLYPH_W  from ROM doa, valid one cycle after ROM samples rom_addr
pix_valid  out  1  pixel valid
pix_ready  in  1  pixel accept
pix_data  out  1  pixel value, 1 = foreground
pix_col  out  3  column 0..7 of current pixel
pix_last  out  1  high with column 7

Behaviour:
- Clock is clka; reset is synchronous, active-high on rsta. Both are fixed.
- Transfers occur on a rising edge with valid&ready high.
- Reset: rom_addr=0, pix_valid=0, pix_data=0, pix_col=0, pix_last=0, fetch FSM=IDLE, holding buffer and shifter empty, req_ready=0 while rsta=1.
- Reset asserted mid-operation discards any in-flight fetch, held byte and partial glyph. There is no pixel output on the edge after reset.
- Fetch FSM:
  - IDLE: req_ready = !hold_full. On accept (edge E0): rom_addr <= {req_char,req_row}, latch inv, go to ADDR.
  - ADDR: the ROM samples rom_addr at edge E1; go to WAIT. req_ready=0.
  - WAIT: at edge E2, hold <= rom_data XOR {8{inv}}, hold_full<=1, go to IDLE. req_ready=0.
- rom_addr holds its value between fetches. It is not cleared after a fetch.
- Shifter:
  - Loads from hold when hold_full and the shifter is empty, or when its last pixel is being accepted that edge (pix_valid&pix_ready&pix_last). hold_full clears on load.
  - Simultaneous load and WAIT capture cannot happen: capture requires hold to have been empty at accept.
  - Loaded shifter: pix_valid=1, pix_col=0, pix_data=shift[7].
  - Each accepted pixel shifts left 1 and increments pix_col. On accepting col 7 without a reload, the shifter empties and pix_valid=0.
  - pix_valid=1 with pix_ready=0: pix_data, pix_col, pix_last hold stable.
- Latency: request accepted at E0 gives the first pixel valid after edge E3.
- Throughput: with req_valid and pix_ready held high, the stream is gapless. A fetch takes 3 cycles, well under the 8-cycle glyph row.
- pix_col wraps 7->0 only via reload. No arithmetic beyond the 3-bit increment.
- Request fields are sampled only at the accept edge; changes at other times are ignored.

Test Plan:
1. Hold rsta 3 cycles with req_valid=1 -> req_ready=0, pix_valid=0, rom_addr=0x000. No accept occurs; after release req_ready=1.
2. Request char 0x41, row 7, inv 0 (ROM model holds 0xFE at 0x417) -> rom_addr=0x417 after E0; pix_valid rises after E3. pix_data sequence 1,1,1,1,1,1,1,0 with pix_last on col 7; then pix_valid=0.
3. Same request with inv=1 -> pixels 0,0,0,0,0,0,0,1.
4. Requests 0x41 rows 2,3,4 back-to-back, pix_ready=1 -> pixels 0x10,0x38,0x6C MSB-first. 24 consecutive pix_valid cycles with no gap; pix_last at pixels 8,16,24.
5. Drop pix_ready for 5 cycles at col 3 of the first glyph, with a second request pending -> outputs frozen at col 3. The second fetch completes into hold; req_ready=0 until hold loads; no pixel lost or duplicated.
6. Assert rsta one cycle at col 4 with a fetch in WAIT -> next cycle pix_valid=0, FSM IDLE. A new request 0x41 row 7 then yields a clean 0xFE stream.
